// File: rtl/muldiv_exec_unit_pkg.sv
// Shared types and constants for the RV32M/RV64M multiply/divide execute unit.
package muldiv_exec_unit_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_t;

  localparam logic [6:0] M_EXT_FUNC7 = 7'b0000001;

endpackage

// File: rtl/muldiv_exec_unit_iter_core.sv
// Iterative step datapath: radix-2 shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            run,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic            last,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [XLEN:0]    sum, shifted;
  logic [XLEN-1:0]  diff;
  logic             ge;

  // hi holds the partial product / running remainder; lo holds the multiplier / dividend-then-quotient.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    ge      = shifted >= {1'b0, b_q};
    diff    = shifted[XLEN-1:0] - b_q;
    if (div_q) begin
      hi_nxt = ge ? diff : shifted[XLEN-1:0];
      lo_nxt = {lo_q[XLEN-2:0], ge};
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign last = (cnt_q == CNT_W'(XLEN - 1));

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    div_d = div_q;
    if (load) begin
      hi_d  = '0;
      lo_d  = a_in;
      b_d   = b_in;
      cnt_d = '0;
      div_d = is_div;
    end else if (run) begin
      hi_d  = hi_nxt;
      lo_d  = lo_nxt;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/muldiv_exec_unit.sv
// M-extension multiply/divide execute unit: decode, FSM, handshakes, sign fixup and special cases.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply in the accept cycle instead of iterating.
module muldiv_exec_unit
  import muldiv_exec_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] rd_tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_tag_out,
  output logic             out_err,
  output logic             busy
);

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_q, op_d, op_in;
  logic             neg_q, neg_d, err_q, err_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             a_neg, b_neg, neg_in, is_div_in, is_rem_in, div_zero, div_ovf;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic             core_load, core_run, core_last;
  logic [XLEN-1:0]  core_hi, core_lo;

  // Products negate across the full 2*XLEN width before the field pick; quotient/remainder negate per field.
  function automatic logic [XLEN-1:0] fix_select(input muldiv_op_t op, input logic neg,
                                                  input logic [2*XLEN-1:0] raw);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   field;
    prod = neg ? ('0 - raw) : raw;
    case (op)
      MUL:                 field = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: field = prod[2*XLEN-1:XLEN];
      DIV, DIVU:           field = raw[XLEN-1:0];
      default:             field = raw[2*XLEN-1:XLEN];
    endcase
    if (op[2] && neg) field = '0 - field;
    return field;
  endfunction

  always_comb begin
    op_in     = muldiv_op_t'(func3);
    is_div_in = func3[2];
    is_rem_in = func3[2] & func3[1];
    a_neg     = (op_in inside {MUL, MULH, MULHSU, DIV, REM}) & rs1[XLEN-1];
    b_neg     = (op_in inside {MUL, MULH, DIV, REM}) & rs2[XLEN-1];
    a_mag     = a_neg ? ('0 - rs1) : rs1;
    b_mag     = b_neg ? ('0 - rs2) : rs2;
    neg_in    = is_rem_in ? a_neg : (a_neg ^ b_neg);
    div_zero  = is_div_in && (rs2 == '0);
    div_ovf   = (op_in == DIV || op_in == REM) && (rs1 == SMIN) && (rs2 == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    err_d     = err_q;
    result_d  = result_q;
    tag_d     = tag_q;
    core_load = 1'b0;
    core_run  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && in_valid) begin
          op_d    = op_in;
          neg_d   = neg_in;
          tag_d   = rd_tag_in;
          err_d   = 1'b0;
          state_d = DONE;
          if (func7 != M_EXT_FUNC7) begin
            result_d = '0;
            err_d    = 1'b1;
          end else if (div_zero) begin
            result_d = is_rem_in ? rs1 : '1;
          end else if (div_ovf) begin
            result_d = is_rem_in ? '0 : rs1;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div_in) begin
            result_d = fix_select(op_in, neg_in, fast_prod);
`endif
          end else begin
            core_load = 1'b1;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          core_run = 1'b1;
          if (core_last) begin
            result_d = fix_select(op_q, neg_q, {core_hi, core_lo});
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      result_q <= result_d;
      tag_q    <= tag_d;
    end
  end

  muldiv_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (core_load),
    .run    (core_run),
    .is_div (is_div_in),
    .a_in   (a_mag),
    .b_in   (b_mag),
    .last   (core_last),
    .hi_nxt (core_hi),
    .lo_nxt (core_lo)
  );

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign result     = result_q;
  assign rd_tag_out = tag_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_muldiv_exec_unit.sv
// Scoreboard bench for muldiv_exec_unit: driver queues expected responses, a negedge monitor checks them.
module tb_muldiv_exec_unit;
  import muldiv_exec_unit_pkg::*;

  localparam int  XLEN   = 32;
  localparam int  TAG_W  = 5;
  localparam time PERIOD = 10;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;
  localparam logic [6:0] F7_OK  = 7'b0000001;
  localparam logic [6:0] F7_BAD = 7'b0100000;

  logic             clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic [2:0]       func3;
  logic [6:0]       func7;
  logic [XLEN-1:0]  rs1, rs2, result;
  logic [TAG_W-1:0] rd_tag_in, rd_tag_out;

  typedef struct {
    int               id;
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               lat;
    time              t_acc;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  bit   first_seen = 1'b0;

  muldiv_exec_unit #(
    .XLEN  (XLEN),
    .TAG_W (TAG_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .func3      (func3),
    .func7      (func7),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd_tag_in  (rd_tag_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .rd_tag_out (rd_tag_out),
    .out_err    (out_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: checks every cycle the DUT presents a result, pops on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 1'b0);
      end else begin
        e = expq[0];
        chk($sformatf("op%0d_result", e.id), result, e.res);
        chk($sformatf("op%0d_tag", e.id), rd_tag_out, e.tag);
        chk($sformatf("op%0d_err", e.id), out_err, e.err);
        chk($sformatf("op%0d_in_ready_low", e.id), in_ready, 1'b0);
        if (!first_seen) begin
          chk($sformatf("op%0d_latency", e.id), ($time - e.t_acc) / PERIOD, e.lat);
          first_seen = 1'b1;
        end
        if (out_ready) begin
          void'(expq.pop_front());
          first_seen = 1'b0;
        end
      end
    end
  end

  task automatic drive_accept(input int id, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] er,
                              input logic ee, input int lat, input bit push);
    int   n = 0;
    exp_t e;
    in_valid  = 1'b1;
    func3     = f3;
    func7     = f7;
    rs1       = a;
    rs2       = b;
    rd_tag_in = tag;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      chk($sformatf("op%0d_accept_timeout", id), in_ready, 1'b1);
    end else if (push) begin
      e.id = id; e.res = er; e.tag = tag; e.err = ee; e.lat = lat; e.t_acc = $time;
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue(input int id, input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                       input logic [XLEN-1:0] er, input int lat);
    @(posedge clk);
    #1;
    drive_accept(id, f3, F7_OK, a, b, tag, er, 1'b0, lat, 1'b1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (expq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, expq.size(), 0);
  endtask

  initial begin
    #(PERIOD * 10000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    func3 = '0; func7 = '0; rs1 = '0; rs2 = '0; rd_tag_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", result, '0);
    chk("reset_tag", rd_tag_out, '0);
    chk("reset_err", out_err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);

    issue(1,  MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT);
    issue(2,  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, MUL_LAT);
    issue(3,  MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, MUL_LAT);
    issue(4,  MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, MUL_LAT);
    issue(5,  MUL,    32'h8000_0000, 32'd2,        5'd9,  32'h0000_0000, MUL_LAT);
    issue(6,  MULHU,  32'h8000_0000, 32'd2,        5'd10, 32'h0000_0001, MUL_LAT);
    issue(7,  DIV,    32'hFFFF_FFF9, 32'd2,        5'd11, 32'hFFFF_FFFD, DIV_LAT);
    issue(8,  REM,    32'hFFFF_FFF9, 32'd2,        5'd12, 32'hFFFF_FFFF, DIV_LAT);
    issue(9,  DIVU,   32'd7,        32'd0,        5'd13, 32'hFFFF_FFFF, 1);
    issue(10, REMU,   32'd7,        32'd0,        5'd14, 32'd7,         1);
    issue(11, DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    issue(12, REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1);
    issue(13, DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, DIV_LAT);
    issue(14, REMU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, DIV_LAT);
    issue(15, DIVU,   32'd100,      32'd7,        5'd19, 32'd14,        DIV_LAT);
    issue(16, REMU,   32'd100,      32'd7,        5'd20, 32'd2,         DIV_LAT);
    issue(17, DIV,    32'd7,        32'hFFFF_FFFE, 5'd21, 32'hFFFF_FFFD, DIV_LAT);
    issue(18, REM,    32'd7,        32'hFFFF_FFFE, 5'd22, 32'd1,         DIV_LAT);
    issue(19, MULHSU, 32'd2,        32'h8000_0000, 5'd23, 32'h0000_0001, MUL_LAT);
    drain("drain_vectors");

    // Back-pressure: hold the result for 5 extra cycles.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(20, MUL, 32'd6, 32'd7, 5'd24, 32'd42, MUL_LAT);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reached_done", out_valid, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    drain("drain_stall");
    @(negedge clk);
    chk("stall_back_to_idle", in_ready, 1'b1);

    @(posedge clk); #1;
    drive_accept(21, DIV, F7_BAD, 32'd5, 32'd0, 5'd3, 32'd0, 1'b1, 1, 1'b1);
    drain("drain_illegal");

    // Flush in the tenth CALC cycle, then offer the next op right away.
    issue(22, DIV, 32'd100, 32'd7, 5'd25, 32'd0, 0);
    void'(expq.pop_back());
    repeat (9) @(posedge clk);
    #1;
    chk("busy_in_calc", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_calc_to_idle", in_ready, 1'b1);
    drive_accept(23, DIVU, F7_OK, 32'd100, 32'd7, 5'd12, 32'd14, 1'b0, DIV_LAT, 1'b1);
    drain("drain_after_flush");

    @(posedge clk); #1;
    in_valid = 1'b1; flush = 1'b1; func3 = MUL; func7 = F7_OK; rs1 = 32'd3; rs2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_no_accept_busy", busy, 1'b0);
    chk("flush_idle_no_accept_ready", in_ready, 1'b1);

    // Reset in the middle of CALC clears every output at once.
    @(posedge clk); #1;
    drive_accept(24, DIVU, F7_OK, 32'd100, 32'd7, 5'd17, 32'd0, 1'b0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 1'b0);
    chk("midreset_result", result, '0);
    chk("midreset_tag", rd_tag_out, '0);
    chk("midreset_err", out_err, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_in_ready", in_ready, 1'b1);

    issue(25, MULHU, 32'h8000_0000, 32'd2, 5'd26, 32'h0000_0001, MUL_LAT);
    drain("drain_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_exec_unit.md
Name: muldiv_exec_unit

Overview:
Execute-stage RV32M/RV64M multiply/divide unit, a parametrised successor to the combinational ALU-control decode. It decodes func3/func7 for the M-extension itself, holds one operation in flight, and runs it iteratively over multiple cycles. It uses valid/ready handshakes on both sides; the pipeline stalls on `in_ready`/`busy`. It carries the destination register tag through to writeback.

Parameters:
XLEN, 32, operand/result width (32 or 64)
TAG_W, 5, width of destination register tag carried with the op

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill any in-flight op (branch mispredict / trap)
in_valid  in  1  op offered
in_ready  out  1  unit can accept (high only in IDLE)
func3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
func7  in  7  must be 7'b0000001 for legal op
rs1  in  XLEN  operand A
rs2  in  XLEN  operand B
rd_tag_in  in  TAG_W  destination tag
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  XLEN  result
rd_tag_out  out  TAG_W  tag of result
out_err  out  1  func7 was illegal; result forced to 0
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, result=0, rd_tag_out=0, out_err=0, busy=0, in_ready=1 after release.
- FSM IDLE -> CALC -> DONE -> IDLE.
- IDLE: in_ready=1. Accept on in_valid&in_ready.
  - Latch op, tag, and operand magnitudes. Record the sign fix per op: MULHSU treats rs1 signed, rs2 unsigned; MULHU/DIVU/REMU are unsigned.
  - Clear the iteration counter; go to CALC.
- Short paths (accept -> DONE the next cycle, skipping CALC):
  - Illegal func7: result=0, out_err=1.
  - DIV/DIVU by zero: quotient = all ones.
  - REM/REMU by zero: result = rs1.
  - DIV overflow (rs1 = -2^(XLEN-1), rs2 = -1): quotient = rs1.
  - REM overflow: result = 0.
- CALC, multiply: radix-2 shift-add over magnitudes into a 2*XLEN accumulator.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC length and exit: exactly XLEN cycles, counter 0..XLEN-1. Then apply the sign fix (two's-complement negate of product or quotient/remainder), select the field, and go to DONE.
- Result field select: MUL = low XLEN; MULH/MULHSU/MULHU = high XLEN.
- Remainder sign follows the dividend; quotient sign = sign(rs1) XOR sign(rs2).
- Latency, accept edge to out_valid: iterative ops XLEN+1 cycles; short paths 1 cycle.
- DONE: out_valid=1; result and rd_tag_out are stable while out_valid&!out_ready. On out_valid&out_ready go to IDLE, out_valid=0 next cycle.
  - No same-cycle re-accept: in_ready is 0 in DONE.
- flush:
  - In CALC or DONE: next state IDLE, out_valid=0, result discarded.
  - In IDLE: flush wins over in_valid (no accept).
- Reset mid-operation: immediate return to IDLE; partial state is discarded.
- Width rules: all internal arithmetic is XLEN+1 or 2*XLEN wide; no truncation before field select.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: multiply ops use the single-cycle operator (signed/unsigned 2*XLEN product computed in the accept cycle), so MUL* latency = 1 cycle, same as the short paths. Divide is unchanged.
- Undefined: iterative multiply, XLEN+1 cycle latency.

Decomposition:
- Shared parameters package additions:
  - enum muldiv_op_t with values MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, encoded = func3.
  - constant M_EXT_FUNC7 = 7'b0000001.
  - state enum muldiv_state_t with values IDLE, CALC, DONE.
- One sub-module: muldiv_iter_core. It contains the per-cycle shift-add/restoring step datapath with its accumulator and counter. The top holds the FSM, handshake, sign fixup and special cases.

Test Plan:
- MUL rs1=7, rs2=-3 (XLEN=32) -> result 0xFFFFFFEB after 33 cycles, tag preserved.
- MULHU rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU rs1=-1, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV rs1=-7, rs2=2 -> -3; REM -> -1; DIVU 7/0 -> 0xFFFFFFFF in 1 cycle; REMU 7/0 -> 7.
- DIV 0x80000000 / -1 -> 0x80000000 and REM -> 0, both in 1 cycle.
- out_ready held low 5 cycles in DONE -> result/tag stable, in_ready=0; then accept and return to IDLE. func7=0100000 -> out_err=1, result 0.
- flush asserted in CALC cycle 10 -> no out_valid; next op is accepted the cycle after flush deasserts. rst_n pulsed mid-CALC -> all outputs 0 immediately.
